// File: rtl/mc51_mem_arb_pkg.sv
// Shared constants and types for the mc51 external-memory arbiter.
package mc51_mem_arb_pkg;

    localparam int ARB_AW       = 16;
    localparam int ARB_DW       = 8;
    localparam int ARB_TMO_CYC  = 15;
    localparam int ARB_TMO_W    = 4;
    localparam int ARB_DBG_MAXW = 4;

    // Read data returned to the owner when the slave never answers.
    localparam logic [7:0] RDATA_TMO = 8'hFF;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CU   = 2'd1,
        ARB_DBG  = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mc51_mem_arb_if.sv
// External memory bus between the arbiter (master) and the memory slave.
// Handshake: an access is in flight while any of rd_n/we_n/psen_n is low.
// addr/wdata are stable for the whole access. The slave completes the access
// by driving rdy=1 (with rdata for reads) in a cycle where a strobe is low;
// the master samples rdy on the rising clk edge and releases all strobes from
// the next cycle. rdy seen while no strobe is low has no effect.
interface mc51_mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 8
) ();
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd_n;
    logic          we_n;
    logic          psen_n;
    logic [DW-1:0] rdata;
    logic          rdy;

    modport master (
        output addr, wdata, rd_n, we_n, psen_n,
        input  rdata, rdy
    );

    modport slave (
        input  addr, wdata, rd_n, we_n, psen_n,
        output rdata, rdy
    );
endinterface

// File: rtl/mc51_wait_timer.sv
// Slave-wait timer: counts enabled cycles since the last clear and flags the
// TMO_CYC-th one so the access can be terminated.
module mc51_wait_timer #(
    parameter int TMO_W   = 4,
    parameter int TMO_CYC = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [TMO_W-1:0] cnt;

    // The access has waited TMO_CYC cycles once the count reaches TMO_CYC-1.
    assign expire = enable & (cnt == TMO_W'(TMO_CYC - 1));

    // Count waiting cycles; clear wins, and the count holds once expired.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expire)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mc51_mem_arb.sv
// Arbitrates the single external memory bus between the mc51 control unit
// and the debug/DMA requester, sequences the strobes, enforces a slave-wait
// timeout and returns one-cycle completion pulses with read data.
module mc51_mem_arb
    import mc51_mem_arb_pkg::*;
#(
    parameter int AW       = ARB_AW,
    parameter int DW       = ARB_DW,
    parameter int TMO_CYC  = ARB_TMO_CYC,
    parameter int TMO_W    = ARB_TMO_W,
    parameter int DBG_MAXW = ARB_DBG_MAXW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_cu_rd_n,
    input  logic          i_cu_we_n,
    input  logic          i_cu_psen_n,
    input  logic [AW-1:0] i_cu_addr,
    input  logic [DW-1:0] i_cu_wdata,
    output logic [DW-1:0] o_cu_rdata,
    output logic          o_cu_data_rdy,
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic          i_dbg_prg,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    output logic [DW-1:0] o_dbg_rdata,
    output logic          o_dbg_ack,
    mc51_mem_arb_if.master mem,
    output logic          o_tmo_err,
    output arb_state_t    o_state
);
    localparam int SW = $clog2(DBG_MAXW + 1);

    arb_state_t    state;
    logic [SW-1:0] starve;
    logic          cu_req, dbg_req, dbg_force;
    logic          cu_grant, dbg_grant;
    logic          in_acc, tmo_expire;

    assign cu_req    = ~i_cu_rd_n | ~i_cu_we_n;
    assign dbg_req   = i_dbg_req;
    assign dbg_force = dbg_req & (starve == SW'(DBG_MAXW));
    assign cu_grant  = (state == ARB_IDLE) & cu_req & ~dbg_force;
    assign dbg_grant = (state == ARB_IDLE) & ~cu_grant & dbg_req;
    assign in_acc    = (state == ARB_CU) | (state == ARB_DBG);
    assign o_state   = state;

    // Timer runs only while an access waits; cleared in IDLE so every grant starts at 0.
    mc51_wait_timer #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~in_acc),
        .enable  (in_acc),
        .expire  (tmo_expire)
    );

    // Count CU grants taken while debug waits; saturates at the forcing threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve <= '0;
        else if (!dbg_req || dbg_grant)
            starve <= '0;
        else if (cu_grant && starve != SW'(DBG_MAXW))
            starve <= starve + 1'b1;
    end

    // Arbitration FSM with registered strobes, bus fields and completion pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ARB_IDLE;
            mem.addr      <= '0;
            mem.wdata     <= '0;
            mem.rd_n      <= 1'b1;
            mem.we_n      <= 1'b1;
            mem.psen_n    <= 1'b1;
            o_cu_rdata    <= '0;
            o_dbg_rdata   <= '0;
            o_cu_data_rdy <= 1'b0;
            o_dbg_ack     <= 1'b0;
            o_tmo_err     <= 1'b0;
        end else begin
            o_cu_data_rdy <= 1'b0;
            o_dbg_ack     <= 1'b0;
            o_tmo_err     <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (cu_grant) begin
                        state     <= ARB_CU;
                        mem.addr  <= i_cu_addr;
                        mem.wdata <= i_cu_wdata;
                        // Write wins when the CU drives both strobes.
                        if (!i_cu_we_n) begin
                            mem.we_n <= 1'b0;
                        end else begin
                            mem.rd_n   <= 1'b0;
                            mem.psen_n <= i_cu_psen_n;
                        end
                    end else if (dbg_grant) begin
                        mem.addr  <= i_dbg_addr;
                        mem.wdata <= i_dbg_wdata;
                        if (i_dbg_we && i_dbg_prg) begin
                            // Program space is read-only: refuse without touching the bus.
                            state     <= ARB_DONE;
                            o_dbg_ack <= 1'b1;
                            o_tmo_err <= 1'b1;
                        end else begin
                            state <= ARB_DBG;
                            if (i_dbg_we) begin
                                mem.we_n <= 1'b0;
                            end else begin
                                mem.rd_n   <= 1'b0;
                                mem.psen_n <= ~i_dbg_prg;
                            end
                        end
                    end
                end
                ARB_CU, ARB_DBG: begin
                    if (mem.rdy || tmo_expire) begin
                        state      <= ARB_DONE;
                        mem.rd_n   <= 1'b1;
                        mem.we_n   <= 1'b1;
                        mem.psen_n <= 1'b1;
                        o_tmo_err  <= ~mem.rdy;
                        if (state == ARB_CU) begin
                            o_cu_data_rdy <= 1'b1;
                            o_cu_rdata    <= mem.rdy ? mem.rdata : DW'(RDATA_TMO);
                        end else begin
                            o_dbg_ack   <= 1'b1;
                            o_dbg_rdata <= mem.rdy ? mem.rdata : DW'(RDATA_TMO);
                        end
                    end
                end
                ARB_DONE: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc51_mem_arb.sv
// Directed bench for mc51_mem_arb: one task per scenario, expected values
// worked out by hand from the arbiter's cycle behaviour.
module tb_mc51_mem_arb;
    import mc51_mem_arb_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cu_rd_n, cu_we_n, cu_psen_n;
    logic [15:0] cu_addr;
    logic [7:0]  cu_wdata;
    logic [7:0]  cu_rdata;
    logic        cu_data_rdy;
    logic        dbg_req, dbg_we, dbg_prg;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [7:0]  dbg_rdata;
    logic        dbg_ack;
    logic        tmo_err;
    arb_state_t  state;

    int n_cmp;
    int n_err;

    mc51_mem_arb_if #(.AW(16), .DW(8)) mem_if ();

    mc51_mem_arb dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_cu_rd_n     (cu_rd_n),
        .i_cu_we_n     (cu_we_n),
        .i_cu_psen_n   (cu_psen_n),
        .i_cu_addr     (cu_addr),
        .i_cu_wdata    (cu_wdata),
        .o_cu_rdata    (cu_rdata),
        .o_cu_data_rdy (cu_data_rdy),
        .i_dbg_req     (dbg_req),
        .i_dbg_we      (dbg_we),
        .i_dbg_prg     (dbg_prg),
        .i_dbg_addr    (dbg_addr),
        .i_dbg_wdata   (dbg_wdata),
        .o_dbg_rdata   (dbg_rdata),
        .o_dbg_ack     (dbg_ack),
        .mem           (mem_if.master),
        .o_tmo_err     (tmo_err),
        .o_state       (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        cu_rd_n = 1'b1; cu_we_n = 1'b1; cu_psen_n = 1'b1;
        cu_addr = '0; cu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_prg = 1'b0;
        dbg_addr = '0; dbg_wdata = '0;
        mem_if.rdy = 1'b0; mem_if.rdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_if.rd_n !== 1'b1 || mem_if.we_n !== 1'b1 || mem_if.psen_n !== 1'b1) begin n_err++; $display("FAIL reset_strobes: got rd/we/psen %b%b%b expected 111", mem_if.rd_n, mem_if.we_n, mem_if.psen_n); end
        n_cmp++; if (mem_if.addr !== 16'h0 || mem_if.wdata !== 8'h0) begin n_err++; $display("FAIL reset_bus: got addr %h wdata %h expected 0000 00", mem_if.addr, mem_if.wdata); end
        n_cmp++; if (cu_data_rdy !== 1'b0 || dbg_ack !== 1'b0 || tmo_err !== 1'b0 || cu_rdata !== 8'h0 || dbg_rdata !== 8'h0) begin n_err++; $display("FAIL reset_outputs: got rdy %b ack %b tmo %b cu %h dbg %h expected all 0", cu_data_rdy, dbg_ack, tmo_err, cu_rdata, dbg_rdata); end
        n_cmp++; if (state !== ARB_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, ARB_IDLE); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cu_read();
        int lo;
        cu_addr = 16'h1234; cu_rd_n = 1'b0; cu_psen_n = 1'b0;
        lo = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_if.rd_n == 1'b0 && mem_if.psen_n == 1'b0 && mem_if.addr == 16'h1234 && state == ARB_CU) lo++;
            if (c == 2) begin mem_if.rdy = 1'b1; mem_if.rdata = 8'h5A; end
        end
        n_cmp++; if (lo !== 3) begin n_err++; $display("FAIL cu_read_strobe_cycles: got %0d expected 3", lo); end
        @(negedge clk);
        n_cmp++; if (cu_data_rdy !== 1'b1 || cu_rdata !== 8'h5A) begin n_err++; $display("FAIL cu_read_data: got rdy %b data %h expected 1 5a", cu_data_rdy, cu_rdata); end
        n_cmp++; if (mem_if.rd_n !== 1'b1 || mem_if.psen_n !== 1'b1 || tmo_err !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 8'h00) begin n_err++; $display("FAIL cu_read_done: got rd %b psen %b tmo %b ack %b dbg %h expected 1 1 0 0 00", mem_if.rd_n, mem_if.psen_n, tmo_err, dbg_ack, dbg_rdata); end
        cu_rd_n = 1'b1; cu_psen_n = 1'b1; mem_if.rdy = 1'b0; mem_if.rdata = 8'h00;
        @(negedge clk);
        n_cmp++; if (cu_data_rdy !== 1'b0 || state !== ARB_IDLE || cu_rdata !== 8'h5A) begin n_err++; $display("FAIL cu_read_after: got rdy %b state %0d data %h expected 0 0 5a", cu_data_rdy, state, cu_rdata); end
    endtask

    task automatic test_timeout();
        int lo;
        bit seen;
        cu_addr = 16'h0100; cu_rd_n = 1'b0; cu_psen_n = 1'b1;
        lo = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (cu_data_rdy) seen = 1'b1;
            else if (mem_if.rd_n == 1'b0) lo++;
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL timeout_completion: got no data_rdy within 40 cycles expected one"); end
        n_cmp++; if (lo !== 15) begin n_err++; $display("FAIL timeout_strobe_cycles: got %0d expected 15", lo); end
        n_cmp++; if (tmo_err !== 1'b1 || cu_rdata !== 8'hFF) begin n_err++; $display("FAIL timeout_pulse: got tmo %b data %h expected 1 ff", tmo_err, cu_rdata); end
        cu_rd_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (tmo_err !== 1'b0 || cu_data_rdy !== 1'b0 || state !== ARB_IDLE) begin n_err++; $display("FAIL timeout_after: got tmo %b rdy %b state %0d expected 0 0 0", tmo_err, cu_data_rdy, state); end
    endtask

    task automatic test_dbg_write();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_prg = 1'b0;
        dbg_addr = 16'h0040; dbg_wdata = 8'hA5; mem_if.rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_if.we_n !== 1'b0 || mem_if.rd_n !== 1'b1 || mem_if.wdata !== 8'hA5 || mem_if.addr !== 16'h0040) begin n_err++; $display("FAIL dbg_write_bus: got we %b rd %b wdata %h addr %h expected 0 1 a5 0040", mem_if.we_n, mem_if.rd_n, mem_if.wdata, mem_if.addr); end
        n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL dbg_write_early_ack: got %b expected 0", dbg_ack); end
        @(negedge clk);
        n_cmp++; if (dbg_ack !== 1'b1 || mem_if.we_n !== 1'b1 || tmo_err !== 1'b0 || cu_data_rdy !== 1'b0) begin n_err++; $display("FAIL dbg_write_ack: got ack %b we %b tmo %b cu_rdy %b expected 1 1 0 0", dbg_ack, mem_if.we_n, tmo_err, cu_data_rdy); end
        dbg_req = 1'b0; dbg_we = 1'b0; mem_if.rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (dbg_ack !== 1'b0 || state !== ARB_IDLE) begin n_err++; $display("FAIL dbg_write_after: got ack %b state %0d expected 0 0", dbg_ack, state); end
    endtask

    task automatic test_starvation();
        int  cu_done;
        bit  got_ack;
        cu_addr = 16'h0300; cu_rd_n = 1'b0; cu_psen_n = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_prg = 1'b0; dbg_addr = 16'h0200;
        mem_if.rdy = 1'b1; mem_if.rdata = 8'h11;
        @(negedge clk);
        n_cmp++; if (state !== ARB_CU || mem_if.addr !== 16'h0300) begin n_err++; $display("FAIL starve_first_grant: got state %0d addr %h expected 1 0300", state, mem_if.addr); end
        cu_done = 0; got_ack = 1'b0;
        for (int c = 0; c < 40 && !got_ack; c++) begin
            @(negedge clk);
            if (cu_data_rdy) cu_done++;
            if (dbg_ack) got_ack = 1'b1;
        end
        n_cmp++; if (got_ack !== 1'b1) begin n_err++; $display("FAIL starve_dbg_ack: got no ack within 40 cycles expected one"); end
        n_cmp++; if (cu_done !== 4) begin n_err++; $display("FAIL starve_cu_grants: got %0d expected 4", cu_done); end
        n_cmp++; if (dbg_rdata !== 8'h11) begin n_err++; $display("FAIL starve_dbg_rdata: got %h expected 11", dbg_rdata); end
        cu_rd_n = 1'b1; dbg_req = 1'b0; mem_if.rdy = 1'b0; mem_if.rdata = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rd_we_both();
        cu_addr = 16'h0500; cu_wdata = 8'h3C; cu_rd_n = 1'b0; cu_we_n = 1'b0; cu_psen_n = 1'b1;
        mem_if.rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_if.we_n !== 1'b0 || mem_if.rd_n !== 1'b1 || mem_if.wdata !== 8'h3C || mem_if.addr !== 16'h0500) begin n_err++; $display("FAIL both_strobes_write: got we %b rd %b wdata %h addr %h expected 0 1 3c 0500", mem_if.we_n, mem_if.rd_n, mem_if.wdata, mem_if.addr); end
        @(negedge clk);
        n_cmp++; if (cu_data_rdy !== 1'b1 || mem_if.we_n !== 1'b1) begin n_err++; $display("FAIL both_strobes_done: got rdy %b we %b expected 1 1", cu_data_rdy, mem_if.we_n); end
        cu_rd_n = 1'b1; cu_we_n = 1'b1; mem_if.rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dbg_prg_write();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_prg = 1'b1; dbg_addr = 16'h0010; dbg_wdata = 8'h77;
        @(negedge clk);
        n_cmp++; if (dbg_ack !== 1'b1 || tmo_err !== 1'b1) begin n_err++; $display("FAIL prg_write_ack: got ack %b tmo %b expected 1 1", dbg_ack, tmo_err); end
        n_cmp++; if (mem_if.we_n !== 1'b1 || mem_if.rd_n !== 1'b1 || mem_if.psen_n !== 1'b1) begin n_err++; $display("FAIL prg_write_strobes: got we/rd/psen %b%b%b expected 111", mem_if.we_n, mem_if.rd_n, mem_if.psen_n); end
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_prg = 1'b0;
        @(negedge clk);
        n_cmp++; if (dbg_ack !== 1'b0 || tmo_err !== 1'b0 || state !== ARB_IDLE) begin n_err++; $display("FAIL prg_write_after: got ack %b tmo %b state %0d expected 0 0 0", dbg_ack, tmo_err, state); end
    endtask

    task automatic test_reset_mid_access();
        int rdy_seen;
        cu_addr = 16'h0777; cu_rd_n = 1'b0; cu_psen_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (state !== ARB_CU || mem_if.rd_n !== 1'b0) begin n_err++; $display("FAIL mid_reset_setup: got state %0d rd %b expected 1 0", state, mem_if.rd_n); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_if.rd_n !== 1'b1 || mem_if.psen_n !== 1'b1 || state !== ARB_IDLE) begin n_err++; $display("FAIL mid_reset_async: got rd %b psen %b state %0d expected 1 1 0", mem_if.rd_n, mem_if.psen_n, state); end
        cu_rd_n = 1'b1;
        mem_if.rdy = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        rdy_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cu_data_rdy) rdy_seen++;
        end
        n_cmp++; if (rdy_seen !== 0 || state !== ARB_IDLE || mem_if.addr !== 16'h0000) begin n_err++; $display("FAIL mid_reset_after: got rdy_count %0d state %0d addr %h expected 0 0 0000", rdy_seen, state, mem_if.addr); end
        mem_if.rdy = 1'b0;
    endtask

    // Scenario sequence and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_cu_read();
        test_timeout();
        test_dbg_write();
        test_starvation();
        test_rd_we_both();
        test_dbg_prg_write();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
